mul_share_arbiter: RTL
======================

Name: mul_share_arbiter

Overview:
- Shares one sequential shift-add unsigned multiplier among NUM_REQ requesters.
- Round-robin grant; per-requester valid/ready request channel; one shared response channel carrying the requester ID, with backpressure.
- Sits between several datapath clients and the multiplier core, which it sequences: start, WIDTH add/shift iterations, result hold.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 4, operand width in bits; product is 2*WIDTH.
- ID_W, 2, requester-ID width (= clog2(NUM_REQ)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_x  in  NUM_REQ*WIDTH  multiplicands, requester i at [i*WIDTH +: WIDTH].
- req_y  in  NUM_REQ*WIDTH  multipliers, same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  requester that issued the result.
- resp_p  out  2*WIDTH  unsigned product x*y.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Sampled on the rising edge only.
- Reset values: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_p=0, busy=0, last_grant=NUM_REQ-1 (requester 0 wins first), iteration counter=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid is high, grant = first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[grant]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: latch req_x/req_y of grant, load accumulator {0, y}, cnt=0, last_grant=grant, state -> BUSY.
  - If no req_valid is high: stay in IDLE, req_ready=0.
- BUSY, one iteration per cycle:
  - If acc[0], acc high part += x, using a WIDTH+1-bit sum to keep the carry; then shift the whole accumulator right 1.
  - cnt increments each cycle.
  - After the WIDTH-th iteration: resp_p = final product, resp_id = latched grant, resp_valid=1, state -> RESP.
- RESP:
  - resp_valid, resp_id, resp_p stay stable until resp_valid && resp_ready.
  - On that edge: resp_valid=0, state -> IDLE.
- Latency: accept edge T0; resp_valid is high in the cycle after edge T0+WIDTH. With resp_ready held high, the minimum issue interval is WIDTH+2 cycles.
- req_ready is 0 in BUSY and RESP. A requester must hold valid and operands until its ready is seen. The arbiter never drops or reorders an accepted request.
- Arithmetic: unsigned, exact. 0*y=0; (2^WIDTH-1)^2 = 2^(2*WIDTH) - 2^(WIDTH+1) + 1, with no overflow.
- Simultaneous requests: exactly one is granted per IDLE cycle; requests that lose keep waiting. With all requesters persistently valid, each is granted once per NUM_REQ transactions.
- A req_valid change in the same cycle as grant evaluation: the value sampled in that IDLE cycle decides.
- Reset asserted in BUSY or RESP: the in-flight result is discarded with no resp_valid pulse, and all reset values are restored on that edge.
- Reset in the same cycle as a grant: the reset wins; req_ready must be 0 that cycle, so no handshake occurs.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, BUSY=2'b01, RESP=2'b10.
  - Default WIDTH/NUM_REQ constants.
  - A round-robin next-grant function.
- One sub-module, shift_add_mul_core. Interface: start, x, y in; done pulse and 2*WIDTH product out; internal (2*WIDTH+1)-bit accumulator and counter.
- The arbiter holds the FSM, grant logic and response register.

Test Plan:
- Single request: requester 1, x=13, y=11, resp_ready=1 -> req_ready[1] pulses once; after 5 cycles (WIDTH+1), resp_valid=1, resp_id=1, resp_p=143.
- Boundary operands: x=15,y=15 -> 225; x=0,y=9 -> 0; x=7,y=0 -> 0; x=1,y=1 -> 1.
- All four requesters valid from reset with distinct operands -> grants and resp_id in order 0,1,2,3, then 0 again. Each product is correct; req_ready is never high in BUSY/RESP.
- Fairness after last_grant=2, with requesters 0 and 3 valid -> 3 granted first, then 0.
- Backpressure: resp_ready low 6 cycles in RESP -> resp_valid/resp_id/resp_p stable and no new acceptance while pending. Acceptance resumes in the IDLE cycle after the handshake.
- Reset pulsed on the 2nd BUSY cycle -> no resp_valid; all outputs at reset values next cycle. A following request from requester 0 (x=5,y=6) yields resp_p=30.

Source files
------------

// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mul_share_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int MAX_REQ     = 16;
    localparam int MAX_REQ_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // First valid requester after 'last', wrapping; returns 'last' when none is valid.
    function automatic int rr_next_grant(input logic [MAX_REQ-1:0] valid,
                                         input int num_req, input int last);
        int                   grant;
        logic                 found;
        logic [MAX_REQ_W-1:0] idx;
        grant = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = MAX_REQ_W'((last + i) % num_req);
            if (!found && i <= num_req && valid[idx]) begin
                grant = 32'(idx);
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the clients and the shared multiplier arbiter.
interface mul_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ*WIDTH-1:0] req_y;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [2*WIDTH-1:0]       resp_p;
    logic                     busy;

    modport master (
        output req_valid, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_p, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_id, resp_p, busy
    );
endinterface

// File: rtl/mul_share_arbiter_core.sv
// Sequential shift-add unsigned multiplier: one add/shift step per cycle, WIDTH steps.
module shift_add_mul_core
    import mul_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   x_i,
    input  logic [WIDTH-1:0]   y_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] p_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH:0]   acc_q;
    logic [2*WIDTH:0]   acc_add;
    logic [2*WIDTH:0]   acc_nxt;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   x_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_q;

    // Upper WIDTH+1 bits hold the partial sum so the add carry survives the shift.
    always_comb begin
        sum     = acc_q[2*WIDTH:WIDTH] + {1'b0, x_q};
        acc_add = acc_q[0] ? {sum, acc_q[WIDTH-1:0]} : acc_q;
        acc_nxt = acc_add >> 1;
    end

    assign done_o = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign p_o    = acc_nxt[2*WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            x_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            acc_q <= {{(WIDTH+1){1'b0}}, y_i};
            x_q   <= x_i;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) run_q <= 1'b0;
        end
    end
endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among NUM_REQ requesters.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                rst,
    mul_share_arbiter_if.slave bus
);
    state_e             state_q;
    logic [ID_W-1:0]    last_grant_q;
    logic               resp_valid_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [2*WIDTH-1:0] resp_p_q;

    logic [ID_W-1:0]    grant;
    logic               accept;
    logic [WIDTH-1:0]   x_sel;
    logic [WIDTH-1:0]   y_sel;
    logic               core_done;
    logic [2*WIDTH-1:0] core_p;
    logic [WIDTH-1:0]   x_arr [NUM_REQ];
    logic [WIDTH-1:0]   y_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign x_arr[i] = bus.req_x[i*WIDTH +: WIDTH];
        assign y_arr[i] = bus.req_y[i*WIDTH +: WIDTH];
    end

    // Reset masks the grant so no handshake can complete on a reset edge.
    always_comb begin
        grant  = ID_W'(rr_next_grant(MAX_REQ'(bus.req_valid), NUM_REQ, int'(last_grant_q)));
        accept = (state_q == ST_IDLE) && (|bus.req_valid) && !rst;
        x_sel  = x_arr[grant];
        y_sel  = y_arr[grant];
    end

    assign bus.req_ready  = accept ? (NUM_REQ'(1) << grant) : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_p     = resp_p_q;
    assign bus.busy       = (state_q != ST_IDLE);

    shift_add_mul_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept),
        .x_i     (x_sel),
        .y_i     (y_sel),
        .done_o  (core_done),
        .p_o     (core_p)
    );

    // last_grant_q doubles as the ID of the in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_p_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    last_grant_q <= grant;
                    state_q      <= ST_BUSY;
                end
                ST_BUSY: if (core_done) begin
                    resp_valid_q <= 1'b1;
                    resp_id_q    <= last_grant_q;
                    resp_p_q     <= core_p;
                    state_q      <= ST_RESP;
                end
                ST_RESP: if (bus.resp_ready) begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
